// File: rtl/dmem_ls.sv
// Byte-addressable data memory with load/store unit: init sweep on reset,
// little-endian sub-word stores, sign/zero-extended loads, 1-cycle responses.
module dmem_ls #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1,
    localparam int unsigned OFF = $clog2(DATA_WIDTH / 8),
    localparam int unsigned AW  = $clog2(MEM_DEPTH) + OFF
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [AW-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  init_busy
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned WW = $clog2(MEM_DEPTH);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic [WW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic                  illegal;
    logic [WW-1:0]         word_idx;
    logic [2:0]            off3;
    logic [7:0]            size_mask;
    logic [7:0]            lane_mask8;
    logic [NB-1:0]         lane_mask;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [DATA_WIDTH-1:0] rd_sh;
    logic [DATA_WIDTH-1:0] low_mask;
    logic [DATA_WIDTH-1:0] ext;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  sign;

    assign req_ready = (state == ST_READY);
    assign init_busy = (state == ST_INIT);
    assign accept    = req_valid && req_ready;
    assign word_idx  = req_addr[AW-1:OFF];
    assign off3      = 3'(req_addr[OFF-1:0]);

    // Request decode: legality, byte-lane mask, aligned store data, extended load data
    always_comb begin
        illegal   = 1'b0;
        size_mask = 8'h01;
        low_mask  = DATA_WIDTH'(8'hFF);
        sign      = 1'b0;
        rd_sh     = mem[word_idx] >> {off3, 3'b000};
        wdata_sh  = req_wdata << {off3, 3'b000};
        case (req_size)
            2'b00: begin
                size_mask = 8'h01;
                low_mask  = DATA_WIDTH'(8'hFF);
                sign      = rd_sh[7];
            end
            2'b01: begin
                illegal   = off3[0];
                size_mask = 8'h03;
                low_mask  = DATA_WIDTH'(16'hFFFF);
                sign      = rd_sh[15];
            end
            2'b10: begin
                illegal   = (off3[1:0] != 2'b00);
                size_mask = 8'h0F;
                low_mask  = DATA_WIDTH'(32'hFFFF_FFFF);
                sign      = rd_sh[31];
            end
            default: begin
                illegal   = (DATA_WIDTH == 32) || (off3 != 3'b000);
                size_mask = 8'hFF;
                low_mask  = '1;
                sign      = rd_sh[DATA_WIDTH-1];
            end
        endcase
        lane_mask8 = size_mask << off3;
        lane_mask  = lane_mask8[NB-1:0];
        ext        = req_unsigned ? '0 : {DATA_WIDTH{sign}};
        load_val   = (rd_sh & low_mask) | (ext & ~low_mask);
    end

    // Next-state logic: leave INIT after the last word of the sweep
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && cnt == WW'(MEM_DEPTH - 1)) begin
            state_nxt = ST_READY;
        end
    end

    // State register and sweep counter
    always_ff @(posedge clk) begin
        if (RESET) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                cnt <= cnt + WW'(1);
            end
        end
    end

    // Memory array: sweep writes in INIT, lane-masked stores in READY
    always_ff @(posedge clk) begin
        if (!RESET) begin
            if (state == ST_INIT) begin
                mem[cnt] <= INIT_VALUE;
            end else if (accept && req_write && !illegal) begin
                for (int i = 0; i < NB; i++) begin
                    if (lane_mask[i]) begin
                        mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                    end
                end
            end
        end
    end

    // Response register: one-cycle pulse, data/error held between responses
    always_ff @(posedge clk) begin
        if (RESET) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_error <= illegal;
                rsp_rdata <= (illegal || req_write) ? '0 : load_val;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ls.sv
// Scoreboard bench for dmem_ls: 32-bit and 64-bit instances, depth 16.
module tb_dmem_ls;

    logic clk = 1'b0;
    logic RESET = 1'b1;

    // 32-bit instance signals
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        init_busy;

    // 64-bit instance signals
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic        w_write = 1'b0;
    logic [1:0]  w_size = 2'b00;
    logic        w_unsigned = 1'b0;
    logic [6:0]  w_addr = '0;
    logic [63:0] w_wdata = '0;
    logic        w_rsp_valid;
    logic [63:0] w_rsp_rdata;
    logic        w_rsp_error;
    logic        w_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    int prev_cyc = 0;

    logic [32:0] q32[$];
    logic [64:0] q64[$];

    dmem_ls #(.DATA_WIDTH(32), .MEM_DEPTH(16)) dut (
        .clk(clk), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .init_busy(init_busy)
    );

    dmem_ls #(.DATA_WIDTH(64), .MEM_DEPTH(16)) dut64 (
        .clk(clk), .RESET(RESET),
        .req_valid(w_valid), .req_ready(w_ready), .req_write(w_write),
        .req_size(w_size), .req_unsigned(w_unsigned), .req_addr(w_addr),
        .req_wdata(w_wdata), .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata),
        .rsp_error(w_rsp_error), .init_busy(w_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor, 32-bit instance
    always @(negedge clk) begin
        logic [32:0] e;
        if (rsp_valid === 1'b1) begin
            prev_cyc = last_cyc;
            last_cyc = cyc;
            checks++;
            if (q32.size() == 0) begin
                errors++;
                $display("FAIL rsp32_unexpected: got err=%0b data=%h, required no response", rsp_error, rsp_rdata);
            end else begin
                e = q32.pop_front();
                if ({rsp_error, rsp_rdata} !== e) begin
                    errors++;
                    $display("FAIL rsp32: got err=%0b data=%h, required err=%0b data=%h", rsp_error, rsp_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    // Response monitor, 64-bit instance
    always @(negedge clk) begin
        logic [64:0] e;
        if (w_rsp_valid === 1'b1) begin
            checks++;
            if (q64.size() == 0) begin
                errors++;
                $display("FAIL rsp64_unexpected: got err=%0b data=%h, required no response", w_rsp_error, w_rsp_rdata);
            end else begin
                e = q64.pop_front();
                if ({w_rsp_error, w_rsp_rdata} !== e) begin
                    errors++;
                    $display("FAIL rsp64: got err=%0b data=%h, required err=%0b data=%h", w_rsp_error, w_rsp_rdata, e[64], e[63:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic req32(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [5:0] addr, input logic [31:0] wd,
                         input logic err, input logic [31:0] exp_d);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req32_ready: got %b, required 1", req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        q32.push_back({err, exp_d});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic req64(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [6:0] addr, input logic [63:0] wd,
                         input logic err, input logic [63:0] exp_d);
        @(negedge clk);
        w_valid = 1'b1; w_write = wr; w_size = sz; w_unsigned = uns;
        w_addr = addr; w_wdata = wd;
        q64.push_back({err, exp_d});
        @(posedge clk);
        #1 w_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (q32.size() != 0 || q64.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d/%0d responses outstanding, required 0", name, q32.size(), q64.size());
            q32.delete();
            q64.delete();
        end
    endtask

    // Counts negedges with init_busy high; req_ready must stay low meanwhile
    task automatic count_sweep(input string name);
        int n = 0;
        int bad = 0;
        while (init_busy === 1'b1 && n < 64) begin
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) bad++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL %s_busy_len: got %0d cycles, required 16", name, n);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_ready_during_init: got %0d bad cycles, required 0", name, bad);
        end
        checks++;
        if (req_ready !== 1'b1 || init_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_after: got ready=%b busy=%b, required ready=1 busy=0", name, req_ready, init_busy);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        RESET = 1'b0;
        checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== 34'd0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b e=%b d=%h, required all zero", rsp_valid, rsp_error, rsp_rdata);
        end
        checks++;
        if (init_busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b ready=%b, required busy=1 ready=0", init_busy, req_ready);
        end
        count_sweep("reset");
        req32(1'b0, 2'b10, 1'b0, 6'h00, 32'h0, 1'b0, 32'hFFFF_FFFF);
        drain("reset");
    endtask

    task automatic test_byte_store();
        req32(1'b1, 2'b00, 1'b0, 6'h05, 32'h0000_00A5, 1'b0, 32'h0);
        req32(1'b0, 2'b00, 1'b0, 6'h05, 32'h0, 1'b0, 32'hFFFF_FFA5);
        req32(1'b0, 2'b00, 1'b1, 6'h05, 32'h0, 1'b0, 32'h0000_00A5);
        req32(1'b0, 2'b10, 1'b0, 6'h04, 32'h0, 1'b0, 32'hFFFF_A5FF);
        drain("byte_store");
    endtask

    task automatic test_illegal();
        req32(1'b1, 2'b01, 1'b0, 6'h03, 32'h0000_1234, 1'b1, 32'h0);
        req32(1'b0, 2'b10, 1'b0, 6'h00, 32'h0, 1'b0, 32'hFFFF_FFFF);
        req32(1'b0, 2'b10, 1'b0, 6'h02, 32'h0, 1'b1, 32'h0);
        req32(1'b1, 2'b11, 1'b0, 6'h10, 32'h5555_5555, 1'b1, 32'h0);
        req32(1'b0, 2'b10, 1'b1, 6'h10, 32'h0, 1'b0, 32'hFFFF_FFFF);
        drain("illegal");
    endtask

    task automatic test_back_to_back();
        req32(1'b1, 2'b10, 1'b0, 6'h08, 32'hDEAD_BEEF, 1'b0, 32'h0);
        req32(1'b0, 2'b01, 1'b0, 6'h0A, 32'h0, 1'b0, 32'hFFFF_DEAD);
        drain("b2b");
        checks++;
        if (last_cyc - prev_cyc != 1) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles between responses, required 1", last_cyc - prev_cyc);
        end
    endtask

    task automatic test_half_and_top();
        req32(1'b1, 2'b01, 1'b0, 6'h0E, 32'h0000_8001, 1'b0, 32'h0);
        req32(1'b0, 2'b01, 1'b1, 6'h0E, 32'h0, 1'b0, 32'h0000_8001);
        req32(1'b0, 2'b01, 1'b0, 6'h0E, 32'h0, 1'b0, 32'hFFFF_8001);
        req32(1'b0, 2'b00, 1'b0, 6'h0F, 32'h0, 1'b0, 32'hFFFF_FF80);
        req32(1'b0, 2'b10, 1'b0, 6'h0C, 32'h0, 1'b0, 32'h8001_FFFF);
        req32(1'b1, 2'b10, 1'b0, 6'h3C, 32'h1122_3344, 1'b0, 32'h0);
        req32(1'b0, 2'b00, 1'b1, 6'h3F, 32'h0, 1'b0, 32'h0000_0011);
        req32(1'b0, 2'b01, 1'b1, 6'h3C, 32'h0, 1'b0, 32'h0000_3344);
        drain("half_top");
    endtask

    task automatic test_hold();
        req32(1'b0, 2'b00, 1'b1, 6'h05, 32'h0, 1'b0, 32'h0000_00A5);
        drain("hold");
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0000_00A5 || rsp_error !== 1'b0) begin
                errors++;
                $display("FAIL hold: got v=%b d=%h e=%b, required v=0 d=000000a5 e=0", rsp_valid, rsp_rdata, rsp_error);
            end
        end
    endtask

    task automatic test_mid_sweep_reset();
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        repeat (7) @(negedge clk);
        RESET = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
        req_addr = 6'h00; req_wdata = 32'h0;
        @(negedge clk);
        RESET = 1'b0;
        checks++;
        if (rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_rsp: got d=%h e=%b, required zero", rsp_rdata, rsp_error);
        end
        count_sweep("midreset");
        req_valid = 1'b0;
        req32(1'b0, 2'b10, 1'b0, 6'h00, 32'h0, 1'b0, 32'hFFFF_FFFF);
        req32(1'b0, 2'b10, 1'b0, 6'h08, 32'h0, 1'b0, 32'hFFFF_FFFF);
        drain("midreset");
    endtask

    task automatic test_dword64();
        int n = 0;
        while (w_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (w_ready !== 1'b1) begin
            errors++;
            $display("FAIL w64_ready: got %b, required 1", w_ready);
        end
        req64(1'b1, 2'b11, 1'b0, 7'h08, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0);
        req64(1'b0, 2'b10, 1'b1, 7'h0C, 64'h0, 1'b0, 64'h0000_0000_0123_4567);
        req64(1'b0, 2'b00, 1'b0, 7'h08, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEF);
        req64(1'b0, 2'b01, 1'b0, 7'h0E, 64'h0, 1'b0, 64'h0000_0000_0000_0123);
        req64(1'b0, 2'b11, 1'b1, 7'h00, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        req64(1'b1, 2'b11, 1'b0, 7'h04, 64'h1, 1'b1, 64'h0);
        req64(1'b0, 2'b11, 1'b0, 7'h08, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF);
        drain("dword64");
    endtask

    initial begin
        test_reset();
        test_byte_store();
        test_illegal();
        test_back_to_back();
        test_half_and_top();
        test_hold();
        test_mid_sweep_reset();
        test_dword64();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ls.md
DMEM_LS -- requirements
Module: dmem_ls

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the word width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 1024, giving the word count; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter INIT_VALUE, default all-ones, giving the value written to every word by the init sweep.
REQ-004 The block SHALL derive local OFF = $clog2(DATA_WIDTH/8) and AW = $clog2(MEM_DEPTH) + OFF.
REQ-005 The block SHALL have the following ports:
- clk  in  1  single clock; all state changes on its rising edge.
- RESET  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word32, 11 dword64.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  AW  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  load result, extended.
- rsp_error  out  1  request rejected as misaligned or illegal size.
- init_busy  out  1  init sweep in progress.

Function
REQ-006 The block SHALL use FSM states INIT and READY; RESET forces INIT with sweep counter 0.
REQ-007 In INIT the block SHALL write INIT_VALUE to word[counter] each cycle and increment the counter; after word MEM_DEPTH-1 it SHALL go to READY, so the sweep takes exactly MEM_DEPTH cycles.
REQ-008 The block SHALL drive req_ready = (state == READY) and init_busy = (state == INIT).
REQ-009 A request SHALL be accepted on an edge where req_valid && req_ready; req_valid while not ready SHALL have no effect and SHALL not be queued.
REQ-010 The block SHALL form word index = req_addr[AW-1:OFF] and byte offset = req_addr[OFF-1:0]; byte lanes SHALL be little-endian.
REQ-011 A request SHALL be illegal if size 01 has addr[0] != 0, size 10 has addr[1:0] != 0, size 11 has addr[2:0] != 0, or size 11 is issued while DATA_WIDTH = 32.
REQ-012 A legal store SHALL write only the addressed byte lanes on the accept edge; all other lanes of the word SHALL be unchanged.
REQ-013 A legal load SHALL shift the addressed lanes to bit 0 and extend them per req_unsigned; a full-width load SHALL ignore req_unsigned.
REQ-014 Every accepted request, load or store, SHALL produce rsp_valid = 1 for exactly one cycle, on the cycle after acceptance (latency 1).
REQ-015 Store responses SHALL have rsp_rdata = 0 and rsp_error = 0.
REQ-016 An illegal request SHALL leave memory unchanged and SHALL respond with rsp_error = 1 and rsp_rdata = 0.
REQ-017 rsp_rdata and rsp_error SHALL hold their last values while rsp_valid = 0.
REQ-018 Back-to-back requests SHALL be accepted every cycle in READY.
REQ-019 A load accepted the cycle after a store to the same word SHALL return the merged, newly written data.

Reset
REQ-020 While RESET is high on an edge, the block SHALL set state = INIT, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, and SHALL ignore any request on that edge.
REQ-021 RESET asserted mid-sweep or mid-operation SHALL restart the sweep from word 0, and no pending response SHALL be emitted.
REQ-022 Memory contents SHALL be defined only after the sweep completes.

Verification
REQ-023 Bench with MEM_DEPTH = 16, RESET for 1 cycle -> init_busy high for exactly 16 cycles, then req_ready = 1; a load word @0 returns FFFFFFFF.
REQ-024 Store byte 0xA5 @0x5, then load byte signed @0x5 -> rdata FFFFFFA5; load byte unsigned @0x5 -> 000000A5; load word @0x4 -> FFFFA5FF.
REQ-025 Store half 0x1234 @0x3 -> rsp_error = 1 with rdata 0, and a following load word @0x0 is unchanged.
REQ-026 Store word 0xDEADBEEF @0x8 immediately followed by load half signed @0xA -> second response one cycle after the first, rdata FFFFDEAD.
REQ-027 Assert RESET at cycle 7 of the sweep -> init_busy stays high 16 more cycles, req_ready = 0 throughout, and rsp_valid is never asserted.
REQ-028 With DATA_WIDTH = 64: store dword 0x0123456789ABCDEF @0x8, load word unsigned @0xC -> 0000000001234567; with DATA_WIDTH = 32, size 11 -> rsp_error = 1.
